// File: rtl/fbf_pkg.sv
// fbf_pkg: shared FP32 field widths, special encodings, FSM state type and the
// element-slice helper for the row-major 512-bit matrix packing.
package fbf_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int ELEM_W  = 32;
  localparam int DIM     = 4;
  localparam int N_ELEM  = DIM * DIM;
  localparam int MAT_W   = ELEM_W * N_ELEM;

  localparam logic [ELEM_W-1:0] FP_NAN     = 32'h7FC0_0000;
  localparam logic [ELEM_W-1:0] FP_POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Element idx = 4*row + col; element 0 sits at the most significant bits.
  function automatic logic [ELEM_W-1:0] elem_slice(input logic [MAT_W-1:0] mat,
                                                   input int unsigned idx);
    return mat[MAT_W-1-ELEM_W*idx -: ELEM_W];
  endfunction

endpackage

// File: rtl/fbf_matrix_multiplier_fp32_mac.sv
// fp32_mac: combinational y = round(acc + round(a*b)), non-fused, round to
// nearest even, subnormal inputs read as signed zero, subnormal results flushed.
module fp32_mac
  import fbf_pkg::*;
(
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [ELEM_W-1:0] acc,
  output logic [ELEM_W-1:0] y
);

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] f);
    return f[30:23] == 8'h00;
  endfunction

  // Range check on the rounded, unbounded exponent.
  function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                       input logic [22:0] frac);
    if (e >= 10'sd255)
      return {s, FP_POS_INF[30:0]};
    else if (e <= 10'sd0)
      return {s, 31'd0};
    else
      return {s, e[EXP_W-1:0], frac};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] z);
    logic              s;
    logic [47:0]       prod;
    logic [23:0]       mant;
    logic              rnd;
    logic              st;
    logic [24:0]       m;
    logic signed [9:0] e;
    s    = x[31] ^ z[31];
    prod = 48'd0;
    mant = 24'd0;
    rnd  = 1'b0;
    st   = 1'b0;
    m    = 25'd0;
    e    = 10'sd0;
    if (is_nan(x) || is_nan(z))
      return FP_NAN;
    if ((is_inf(x) && is_zero(z)) || (is_zero(x) && is_inf(z)))
      return FP_NAN;
    if (is_inf(x) || is_inf(z))
      return {s, FP_POS_INF[30:0]};
    if (is_zero(x) || is_zero(z))
      return {s, 31'd0};
    prod = 48'({1'b1, x[FRAC_W-1:0]}) * 48'({1'b1, z[FRAC_W-1:0]});
    e    = $signed({2'b00, x[30:23]}) + $signed({2'b00, z[30:23]}) - 10'(BIAS);
    // Product of two [1,2) significands lies in [1,4): one possible right shift.
    if (prod[47]) begin
      mant = prod[47:24];
      rnd  = prod[23];
      st   = |prod[22:0];
      e    = e + 10'sd1;
    end else begin
      mant = prod[46:23];
      rnd  = prod[22];
      st   = |prod[21:0];
    end
    m = {1'b0, mant} + 25'(rnd & (st | mant[0]));
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    return pack(s, e, m[22:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] z);
    logic [31:0]       big;
    logic [31:0]       sml;
    logic [7:0]        d;
    logic [49:0]       sml_full;
    logic [49:0]       sml_sh;
    logic [49:0]       lost_mask;
    logic              sticky;
    logic [50:0]       sum;
    logic [49:0]       norm;
    logic [5:0]        lz;
    logic              found;
    logic signed [9:0] e;
    logic [24:0]       m;
    logic              rup;
    big = x; sml = z; d = 8'd0; sml_full = '0; sml_sh = '0; lost_mask = '0;
    sticky = 1'b0; sum = '0; norm = '0; lz = 6'd0; found = 1'b0;
    e = 10'sd0; m = 25'd0; rup = 1'b0;
    if (is_nan(x) || is_nan(z))
      return FP_NAN;
    if (is_inf(x) && is_inf(z) && (x[31] != z[31]))
      return FP_NAN;
    if (is_inf(x))
      return x;
    if (is_inf(z))
      return z;
    if (is_zero(x) && is_zero(z))
      return 32'd0;
    if (is_zero(x))
      return z;
    if (is_zero(z))
      return x;
    // Larger magnitude first so the subtraction never goes negative.
    if (z[30:0] > x[30:0]) begin
      big = z;
      sml = x;
    end
    d        = big[30:23] - sml[30:23];
    sml_full = {1'b1, sml[22:0], 26'd0};
    // 26 extra low bits keep everything near the rounding point exact; any
    // bits shifted out beyond that are jammed into the LSB as a sticky flag.
    if (d >= 8'd50) begin
      sml_sh = 50'd0;
      sticky = 1'b1;
    end else begin
      lost_mask = (50'd1 << d) - 50'd1;
      sml_sh    = sml_full >> d;
      sticky    = |(sml_full & lost_mask);
    end
    sml_sh[0] = sml_sh[0] | sticky;
    if (big[31] ^ sml[31])
      sum = {1'b0, 1'b1, big[22:0], 26'd0} - {1'b0, sml_sh};
    else
      sum = {1'b0, 1'b1, big[22:0], 26'd0} + {1'b0, sml_sh};
    if (sum == 51'd0)
      return 32'd0;
    e = $signed({2'b00, big[30:23]});
    if (sum[50]) begin
      norm    = sum[50:1];
      norm[0] = sum[1] | sum[0];
      e       = e + 10'sd1;
    end else begin
      for (int n = 49; n >= 0; n--) begin
        if (!found && sum[n]) begin
          lz    = 6'(49 - n);
          found = 1'b1;
        end
      end
      norm = sum[49:0] << lz;
      e    = e - $signed({4'b0000, lz});
    end
    rup = norm[25] & ((|norm[24:0]) | norm[26]);
    m   = {1'b0, norm[49:26]} + 25'(rup);
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    return pack(big[31], e, m[22:0]);
  endfunction

  assign y = fp_add(acc, fp_mul(a, b));

endmodule

// File: rtl/fbf_matrix_multiplier.sv
// fbf_matrix_multiplier: 4x4 FP32 C = A x B, one MAC step per cycle through a
// shared fp32_mac. Build macro FBF_STATE_OUT_EN adds the `state` output port.
module fbf_matrix_multiplier
  import fbf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             A_stb,
  input  logic             B_stb,
  input  logic [MAT_W-1:0] A,
  input  logic [MAT_W-1:0] B,
  input  logic             result_ack,
  output logic             result_ready,
  output logic [MAT_W-1:0] result
`ifdef FBF_STATE_OUT_EN
  ,
  output logic [3:0]       state
`endif
);

  state_t            state_reg;
  state_t            state_next;
  logic [1:0]        i_reg;
  logic [1:0]        j_reg;
  logic [1:0]        k_reg;
  logic [ELEM_W-1:0] acc_reg;
  logic [MAT_W-1:0]  a_reg;
  logic [MAT_W-1:0]  b_reg;
  logic [ELEM_W-1:0] c_reg [N_ELEM];
  logic [ELEM_W-1:0] a_elem [N_ELEM];
  logic [ELEM_W-1:0] b_elem [N_ELEM];
  logic [ELEM_W-1:0] mac_out;
  logic              last_step;

  for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
    assign a_elem[gi] = elem_slice(a_reg, gi);
    assign b_elem[gi] = elem_slice(b_reg, gi);
  end

  fp32_mac u_mac (
    .a   (a_elem[{i_reg, k_reg}]),
    .b   (b_elem[{k_reg, j_reg}]),
    .acc (acc_reg),
    .y   (mac_out)
  );

  assign last_step    = (i_reg == 2'd3) && (j_reg == 2'd3) && (k_reg == 2'd3);
  assign result_ready = (state_reg == DONE);

`ifdef FBF_STATE_OUT_EN
  assign state = {2'b00, state_reg};
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next state: capture needs both strobes, MAC ends on C[3][3], DONE waits for ack.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (A_stb && B_stb) state_next = MAC;
      MAC:     if (last_step)      state_next = DONE;
      DONE:    if (result_ack)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, index stepping, accumulation and result element writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
      i_reg   <= 2'd0;
      j_reg   <= 2'd0;
      k_reg   <= 2'd0;
      for (int n = 0; n < N_ELEM; n++)
        c_reg[n] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (A_stb && B_stb) begin
            a_reg   <= A;
            b_reg   <= B;
            acc_reg <= '0;
            i_reg   <= 2'd0;
            j_reg   <= 2'd0;
            k_reg   <= 2'd0;
          end
        end
        MAC: begin
          k_reg <= k_reg + 2'd1;
          if (k_reg == 2'd3) begin
            c_reg[{i_reg, j_reg}] <= mac_out;
            acc_reg               <= '0;
            j_reg                 <= j_reg + 2'd1;
            if (j_reg == 2'd3)
              i_reg <= i_reg + 2'd1;
          end else begin
            acc_reg <= mac_out;
          end
        end
        default: ;
      endcase
    end
  end

  // Repack result elements row-major, element (0,0) at the MSBs.
  always_comb begin
    result = '0;
    for (int n = 0; n < N_ELEM; n++)
      result[MAT_W-1-ELEM_W*n -: ELEM_W] = c_reg[n];
  end

endmodule

// File: tb/tb_fbf_matrix_multiplier.sv
// tb_fbf_matrix_multiplier: directed + randomized checks of the 4x4 FP32
// multiplier against a real-arithmetic reference model.
module tb_fbf_matrix_multiplier;

  logic         clk;
  logic         reset;
  logic         A_stb;
  logic         B_stb;
  logic [511:0] A;
  logic [511:0] B;
  logic         result_ack;
  logic         result_ready;
  logic [511:0] result;
`ifdef FBF_STATE_OUT_EN
  logic [3:0]   state;
`endif

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  fbf_matrix_multiplier dut (
    .clk          (clk),
    .reset        (reset),
    .A_stb        (A_stb),
    .B_stb        (B_stb),
    .A            (A),
    .B            (B),
    .result_ack   (result_ack),
    .result_ready (result_ready),
    .result       (result)
`ifdef FBF_STATE_OUT_EN
    ,
    .state        (state)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (real arithmetic) ----------------
  function automatic logic f_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 0);
  endfunction
  function automatic logic f_inf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] == 0);
  endfunction
  function automatic logic f_zero(input logic [31:0] f);
    return f[30:23] == 8'h00;
  endfunction

  // Finite float (subnormals read as signed zero) to its exact real value.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f_zero(f))
      d = {f[31], 63'd0};
    else
      d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Real to float: nearest-even on the significand, then overflow/flush.
  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    logic [28:0] rest;
    logic [24:0] m;
    int          e;
    d = $realtobits(x);
    if (d[62:0] == 0)
      return {d[63], 31'd0};
    e    = int'(d[62:52]) - 1023;
    rest = d[28:0];
    m    = {2'b01, d[51:29]};
    if (rest[28] && ((|rest[27:0]) || m[0]))
      m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e > 127)
      return {d[63], 8'hFF, 23'd0};
    if (e < -126)
      return {d[63], 31'd0};
    return {d[63], 8'(e + 127), m[22:0]};
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] x, input logic [31:0] z);
    if (f_nan(x) || f_nan(z)) return 32'h7FC00000;
    if ((f_inf(x) && f_zero(z)) || (f_zero(x) && f_inf(z))) return 32'h7FC00000;
    if (f_inf(x) || f_inf(z)) return {x[31] ^ z[31], 8'hFF, 23'd0};
    return r2f(f2r(x) * f2r(z));
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] z);
    real s;
    if (f_nan(x) || f_nan(z)) return 32'h7FC00000;
    if (f_inf(x) && f_inf(z) && (x[31] != z[31])) return 32'h7FC00000;
    if (f_inf(x)) return x;
    if (f_inf(z)) return z;
    s = f2r(x) + f2r(z);
    if (s == 0.0) return 32'd0;
    return r2f(s);
  endfunction

  function automatic logic [31:0] ge(input logic [511:0] m, input int r, input int c);
    return m[511-32*(4*r+c) -: 32];
  endfunction

  function automatic logic [511:0] model_mm(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] c;
    logic [31:0]  acc;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        acc = 32'd0;
        for (int k = 0; k < 4; k++)
          acc = m_add(acc, m_mul(ge(a, r, k), ge(b, k, col)));
        c[511-32*(4*r+col) -: 32] = acc;
      end
    end
    return c;
  endfunction

  function automatic logic [511:0] fill(input logic [31:0] v);
    logic [511:0] m;
    for (int n = 0; n < 16; n++) m[511-32*n -: 32] = v;
    return m;
  endfunction

  // full=1: arbitrary bit patterns; full=0: moderate normal numbers.
  function automatic logic [511:0] rand_mat(input bit full);
    logic [511:0] m;
    logic [31:0]  v;
    for (int n = 0; n < 16; n++) begin
      if (full) v = $urandom;
      else      v = {1'($urandom), 8'($urandom_range(144, 110)), 23'($urandom)};
      m[511-32*n -: 32] = v;
    end
    return m;
  endfunction

  // ---------------- checking and driving helpers ----------------
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    end
  endtask

  task automatic strobe_both(input logic [511:0] a, input logic [511:0] b);
    @(negedge clk);
    A = a; B = b; A_stb = 1'b1; B_stb = 1'b1;
    @(posedge clk);
    #1;
    A_stb = 1'b0; B_stb = 1'b0;
  endtask

  // Counts edges after the capture edge until result_ready is seen (bounded).
  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (result_ready) break;
    end
    chk({tag, "_latency"}, 512'(cyc), 512'(64));
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_after_ack"}, {511'd0, result_ready}, 512'd0);
`ifdef FBF_STATE_OUT_EN
    chk({tag, "_state_idle"}, {508'd0, state}, 512'd0);
`endif
  endtask

  task automatic run_txn(input string tag, input logic [511:0] a, input logic [511:0] b,
                         input logic [511:0] exp);
    strobe_both(a, b);
    wait_done(tag);
    chk({tag, "_result"}, result, exp);
    txn++;
    $display("txn %0d %s: C(0,0)=%h C(3,3)=%h", txn, tag, result[511:480], result[31:0]);
    do_ack(tag);
  endtask

  logic [511:0] ident;
  logic [511:0] ma;
  logic [511:0] mb;
  logic [511:0] exp_c;

  initial begin
    reset = 1'b1; A_stb = 1'b0; B_stb = 1'b0; result_ack = 1'b0;
    A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {511'd0, result_ready}, 512'd0);
    chk("reset_result", result, 512'd0);
`ifdef FBF_STATE_OUT_EN
    chk("reset_state", {508'd0, state}, 512'd0);
`endif
    reset = 1'b0;

    // Identity times arbitrary B reproduces B bit-exactly.
    ident = '0;
    for (int n = 0; n < 4; n++) ident[511-32*(5*n) -: 32] = 32'h3F800000;
    mb = rand_mat(1'b0);
    run_txn("identity", ident, mb, mb);

    // All ones times all twos: every element 8.0.
    run_txn("ones_twos", fill(32'h3F800000), fill(32'h40000000), fill(32'h41000000));

    // Overflow to +inf in C(0,0).
    ma = '0; mb = '0;
    ma[511 -: 32] = 32'h7F000000;
    mb[511 -: 32] = 32'h40000000;
    exp_c = '0;
    exp_c[511 -: 32] = 32'h7F800000;
    run_txn("overflow", ma, mb, exp_c);

    // NaN in A(0,0) poisons the whole first row.
    ma[511 -: 32] = 32'h7FC00000;
    exp_c = '0;
    for (int c = 0; c < 4; c++) exp_c[511-32*c -: 32] = 32'h7FC00000;
    run_txn("nan_row", ma, mb, exp_c);

    // A strobe alone never captures.
    @(negedge clk);
    A = fill(32'h3F800000); B = fill(32'h40000000); A_stb = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk("single_strobe_ready", {511'd0, result_ready}, 512'd0);
    end
    B_stb = 1'b1;
    @(posedge clk);
    #1;
    A_stb = 1'b0; B_stb = 1'b0;
    wait_done("late_b");
    chk("late_b_result", result, fill(32'h41000000));

    // Result held steady while ack stays low.
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      chk("hold_ready", {511'd0, result_ready}, 512'd1);
      chk("hold_result", result, fill(32'h41000000));
    end
    txn++;
    $display("txn %0d hold: 100 cycles without ack", txn);
    do_ack("hold");

    // Reset in the middle of MAC aborts and clears; next run is complete.
    ma = rand_mat(1'b0); mb = rand_mat(1'b0);
    strobe_both(ma, mb);
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midmac_reset_ready", {511'd0, result_ready}, 512'd0);
    chk("midmac_reset_result", result, 512'd0);
    @(negedge clk);
    reset = 1'b0;
    txn++;
    $display("txn %0d reset at MAC cycle 30", txn);
    run_txn("after_reset", ma, mb, model_mm(ma, mb));

    // Ack and strobes at the same edge: ack wins, capture on the next edge.
    ma = rand_mat(1'b0); mb = rand_mat(1'b0);
    strobe_both(ma, mb);
    wait_done("ack_strobe_first");
    chk("ack_strobe_first_result", result, model_mm(ma, mb));
    ma = rand_mat(1'b0); mb = rand_mat(1'b0);
    @(negedge clk);
    A = ma; B = mb; A_stb = 1'b1; B_stb = 1'b1; result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    @(negedge clk);
    chk("ack_strobe_ready_low", {511'd0, result_ready}, 512'd0);
    @(posedge clk);
    #1;
    A_stb = 1'b0; B_stb = 1'b0;
    wait_done("ack_strobe_second");
    chk("ack_strobe_second_result", result, model_mm(ma, mb));
    txn++;
    $display("txn %0d ack+strobe back-to-back", txn);
    do_ack("ack_strobe");

    // Randomized operands against the reference model.
    for (int t = 0; t < 6; t++) begin
      ma = rand_mat(t >= 4);
      mb = rand_mat(t >= 4);
      run_txn((t >= 4) ? "rand_full" : "rand_mod", ma, mb, model_mm(ma, mb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
